// File: rtl/text_render_ctrl.sv
// text_render_ctrl: walks the character RAM, fetches each glyph row from the
// font ROM and paints 8x8 glyphs into the 9-bit bitmap VRAM, one pass per start.
module text_render_ctrl #(
    parameter int COLS   = 32,
    parameter int ROWS   = 16,
    parameter int Y_BASE = 0
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        start,
    input  logic [8:0]  fg_color,
    input  logic [8:0]  bg_color,
    output logic        busy,
    output logic        done,
    output logic [8:0]  cram_rdaddress,
    input  logic [7:0]  cram_q,
    output logic [10:0] font_address,
    input  logic [7:0]  font_q,
    output logic [15:0] vram_wraddress,
    output logic [8:0]  vram_data,
    output logic        vram_wren
);

    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [2:0] {
        IDLE, CADDR, CWAIT, FADDR, FWAIT, WRITE, DONE
    } state_t;

    state_t         state, state_nxt;
    logic [CW-1:0]  col;
    logic [RW-1:0]  row;
    logic [2:0]     r, p;
    logic [7:0]     code, shift;
    logic [8:0]     fg_q, bg_q;
    logic [15:0]    hold_addr, live_addr;
    logic [8:0]     hold_data, live_data;
    logic           last_char;

    assign last_char = (col == CW'(COLS - 1)) && (row == RW'(ROWS - 1));

    // Pixel position: line = Y_BASE + row*8 + r, column = col*8 + p, 256 px per line.
    assign live_addr = {8'(Y_BASE + 8 * int'(row) + int'(r)), 8'(8 * int'(col) + int'(p))};
    assign live_data = shift[3'd7 - p] ? fg_q : bg_q;

    // The write port shows live values while writing and otherwise holds the last write.
    assign vram_wraddress = vram_wren ? live_addr : hold_addr;
    assign vram_data      = vram_wren ? live_data : hold_data;

    // State register.
    always_ff @(posedge clock) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode and per-state strobes.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        vram_wren = 1'b0;
        case (state)
            IDLE:  if (start) state_nxt = CADDR;
            CADDR: begin busy = 1'b1; state_nxt = CWAIT; end
            CWAIT: begin busy = 1'b1; state_nxt = FADDR; end
            FADDR: begin busy = 1'b1; state_nxt = FWAIT; end
            FWAIT: begin busy = 1'b1; state_nxt = WRITE; end
            WRITE: begin
                busy      = 1'b1;
                vram_wren = 1'b1;
                if (p == 3'd7) begin
                    if (r != 3'd7)      state_nxt = FADDR;
                    else if (!last_char) state_nxt = CADDR;
                    else                 state_nxt = DONE;
                end
            end
            DONE:  begin done = 1'b1; state_nxt = IDLE; end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: colour latch, RAM/ROM addressing, glyph shift row and counters.
    always_ff @(posedge clock) begin
        if (rst) begin
            fg_q           <= '0;
            bg_q           <= '0;
            col            <= '0;
            row            <= '0;
            r              <= '0;
            p              <= '0;
            code           <= '0;
            shift          <= '0;
            cram_rdaddress <= '0;
            font_address   <= '0;
            hold_addr      <= '0;
            hold_data      <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    fg_q           <= fg_color;
                    bg_q           <= bg_color;
                    col            <= '0;
                    row            <= '0;
                    cram_rdaddress <= '0;
                end
                CWAIT: begin
                    code         <= cram_q;
                    font_address <= {cram_q, 3'd0};
                    r            <= '0;
                end
                FWAIT: begin
                    shift <= font_q;
                    p     <= '0;
                end
                WRITE: begin
                    hold_addr <= live_addr;
                    hold_data <= live_data;
                    if (p != 3'd7) begin
                        p <= p + 3'd1;
                    end else if (r != 3'd7) begin
                        r            <= r + 3'd1;
                        font_address <= {code, r + 3'd1};
                    end else if (!last_char) begin
                        cram_rdaddress <= cram_rdaddress + 9'd1;
                        if (col == CW'(COLS - 1)) begin
                            col <= '0;
                            row <= row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_text_render_ctrl.sv
// Bench for text_render_ctrl: behavioural cycle model plus literal checks.
module tb_text_render_ctrl;

    localparam int COLS = 32;
    localparam int ROWS = 16;
    localparam int YB   = 0;
    localparam int NCH  = COLS * ROWS;
    localparam int PASS = NCH * 82;

    logic        clock = 1'b0;
    logic        rst   = 1'b1;
    logic        start = 1'b0;
    logic [8:0]  fg_color = '0, bg_color = '0;
    logic        busy, done, vram_wren;
    logic [8:0]  cram_rdaddress, vram_data;
    logic [7:0]  cram_q, font_q;
    logic [10:0] font_address;
    logic [15:0] vram_wraddress;

    logic [7:0] cram [NCH];
    logic [7:0] font [2048];
    logic [8:0] vram [65536];

    int  compared   = 0;
    int  mismatched = 0;
    bit  chk_en     = 0;

    text_render_ctrl #(.COLS(COLS), .ROWS(ROWS), .Y_BASE(YB)) dut (
        .clock(clock), .rst(rst), .start(start),
        .fg_color(fg_color), .bg_color(bg_color),
        .busy(busy), .done(done),
        .cram_rdaddress(cram_rdaddress), .cram_q(cram_q),
        .font_address(font_address), .font_q(font_q),
        .vram_wraddress(vram_wraddress), .vram_data(vram_data), .vram_wren(vram_wren)
    );

    always #5 clock = ~clock;

    // Synchronous-read memories and the VRAM sink.
    always @(posedge clock) begin
        cram_q <= cram[cram_rdaddress];
        font_q <= font[font_address];
        if (vram_wren) vram[vram_wraddress] <= vram_data;
    end

    // Model: m_k = 0 idle, 1..PASS busy cycle number, PASS+1 done cycle.
    int         m_k = 0;
    logic [8:0] m_fg, m_bg;
    always @(posedge clock) begin
        if (rst) m_k <= 0;
        else if (m_k == 0) begin
            if (start) begin m_k <= 1; m_fg <= fg_color; m_bg <= bg_color; end
        end else if (m_k == PASS + 1) m_k <= 0;
        else m_k <= m_k + 1;
    end

    // Outputs implied by the pass schedule: 82 cycles/char = 2 + 8 glyph rows of (2 + 8).
    function automatic void model_out(input int k, output logic eb, output logic ed,
                                      output logic ew, output logic [15:0] ea,
                                      output logic [8:0] edat);
        int c, ch, off, m, rr, pp;
        logic [7:0] f;
        eb = (k >= 1 && k <= PASS);
        ed = (k == PASS + 1);
        ew = 0; ea = '0; edat = '0;
        if (eb) begin
            c = k - 1; ch = c / 82; off = c % 82;
            if (off >= 2) begin
                m = off - 2; rr = m / 10;
                if (m % 10 >= 2) begin
                    pp   = m % 10 - 2;
                    ew   = 1;
                    ea   = 16'((YB + (ch / COLS) * 8 + rr) * 256 + (ch % COLS) * 8 + pp);
                    f    = font[int'(cram[ch]) * 8 + rr];
                    edat = f[7 - pp] ? m_fg : m_bg;
                end
            end
        end
    endfunction

    // Per-cycle comparison against the model.
    always @(negedge clock) begin
        logic eb, ed, ew;
        logic [15:0] ea;
        logic [8:0]  edat;
        if (chk_en) begin
            model_out(m_k, eb, ed, ew, ea, edat);
            compared++;
            if (busy !== eb || done !== ed || vram_wren !== ew ||
                (ew && (vram_wraddress !== ea || vram_data !== edat))) begin
                mismatched++;
                $display("FAIL cycle k=%0d got busy=%b done=%b wren=%b addr=%h data=%h exp busy=%b done=%b wren=%b addr=%h data=%h",
                         m_k, busy, done, vram_wren, vram_wraddress, vram_data, eb, ed, ew, ea, edat);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s got %0d (0x%0h) exp %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // mode 0: full pass with a stray start + colour change; 2: reset at idx 100; 3: partial pass.
    task automatic run_pass(input int mode, output int n_busy, output int n_wr,
                            output int n_done, output int first_wr, output int last_addr,
                            output bit done_ok, output bit finished);
        int  limit;
        bit  prev_busy;
        limit = (mode == 0) ? PASS + 20 : (mode == 2) ? 100 * 82 + 30 : 3000;
        start = 1; @(negedge clock); start = 0;
        n_busy = 0; n_wr = 0; n_done = 0; first_wr = -1; last_addr = -1;
        done_ok = 1; finished = 0; prev_busy = 1;
        for (int c = 0; c < limit; c++) begin
            if (busy) n_busy++;
            if (vram_wren) begin
                n_wr++;
                if (first_wr < 0) first_wr = c;
                last_addr = int'(vram_wraddress);
            end
            if (done) begin
                n_done++;
                if (!(prev_busy && !busy)) done_ok = 0;
                finished = 1;
            end
            prev_busy = busy;
            if (mode == 0 && c == 5000) begin start = 1; fg_color = ~fg_color; bg_color = ~bg_color; end
            if (mode == 0 && c == 5001) start = 0;
            if (mode == 2 && c == 100 * 82 + 4) begin
                chk("wren_before_rst", int'(vram_wren), 1);
                rst = 1;
            end
            if (mode == 2 && c == 100 * 82 + 5) begin
                chk("wren_after_rst", int'(vram_wren), 0);
                chk("done_after_rst", int'(done), 0);
                rst = 0;
            end
            if (finished) break;
            @(negedge clock);
        end
    endtask

    initial begin
        int  nb, nw, nd, fw, la;
        bit  dok, fin;
        int  exp1 [8] = '{'h1FF, 0, 0, 0, 0, 0, 0, 'h1FF};

        for (int i = 0; i < NCH; i++)  cram[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 2048; i++) font[i] = 8'($urandom);
        cram[0]     = 8'h41;
        font['h208] = 8'h81;
        cram[33]    = 8'h02;
        font['h10]  = 8'hF0;

        // Reset for 3 cycles; start asserted together with rst must lose.
        rst = 1;
        @(negedge clock); chk_en = 1;
        @(negedge clock); start = 1;
        @(negedge clock); rst = 0; start = 0;
        chk("rst_cram_addr", int'(cram_rdaddress), 0);
        chk("rst_font_addr", int'(font_address), 0);
        chk("rst_vram_addr", int'(vram_wraddress), 0);
        chk("rst_vram_data", int'(vram_data), 0);
        repeat (100) @(negedge clock);
        chk("idle_busy", int'(busy), 0);
        chk("idle_cram_addr", int'(cram_rdaddress), 0);
        chk("idle_vram_addr", int'(vram_wraddress), 0);

        // Full pass; mid-pass start and colour change must be ignored.
        fg_color = 9'h1FF; bg_color = 9'h000;
        run_pass(0, nb, nw, nd, fw, la, dok, fin);
        chk("pass_finished", int'(fin), 1);
        chk("busy_cycles", nb, 41984);
        chk("write_cycles", nw, 32768);
        chk("done_pulses", nd, 1);
        chk("done_when_busy_falls", int'(dok), 1);
        chk("first_write_latency", fw, 4);
        chk("last_write_addr", la, 32767);
        for (int i = 0; i < 8; i++) chk($sformatf("glyph0_px%0d", i), int'(vram[i]), exp1[i]);
        for (int i = 0; i < 8; i++) chk($sformatf("glyph33_px%0d", i), int'(vram[2056 + i]), (i < 4) ? 'h1FF : 0);
        repeat (5) @(negedge clock);
        chk("idle_after_pass", int'(busy), 0);

        // Reset while writing character 100, then restart from character 0.
        fg_color = 9'h123; bg_color = 9'h0F0;
        run_pass(2, nb, nw, nd, fw, la, dok, fin);
        chk("no_done_after_abort", nd, 0);
        fg_color = 9'h0F0; bg_color = 9'h00F;
        run_pass(3, nb, nw, nd, fw, la, dok, fin);
        chk("restart_first_write", fw, 4);
        chk("restart_no_done", nd, 0);
        for (int i = 0; i < 8; i++) chk($sformatf("restart_px%0d", i), int'(vram[i]), (i == 0 || i == 7) ? 'h0F0 : 'h00F);
        chk("restart_glyph33_px0", int'(vram[2056]), 'h0F0);
        chk("restart_glyph33_px7", int'(vram[2063]), 'h00F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/text_render_ctrl.md
Name: text_render_ctrl

Overview:
- Sequencer that renders the 512-entry character RAM (cram) through the 2048x8 font ROM into the 64K x 9-bit bitmap VRAM (vram64k) as 8x8 glyphs.
- Drives cram read port, font address, and vram64k write port; the display scan-out keeps vram64k's read port.
- One render pass per start pulse.

Parameters:
- COLS, 32, characters per text row; COLS*8 <= 256.
- ROWS, 16, text rows; COLS*ROWS <= 512.
- Y_BASE, 0, first pixel line in VRAM; Y_BASE + ROWS*8 <= 256.

Ports:
- clock  in  1  system clock, all logic on posedge
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle request to render a full screen
- fg_color  in  9  foreground pixel value, sampled on accepted start
- bg_color  in  9  background pixel value, sampled on accepted start
- busy  out  1  render pass in progress
- done  out  1  one-cycle pulse after final VRAM write
- cram_rdaddress  out  9  cram read address (registered)
- cram_q  in  8  cram read data, valid 1 edge after the address is sampled
- font_address  out  11  font ROM address = {code, glyph_row} (registered)
- font_q  in  8  font data; bit 7 = leftmost pixel
- vram_wraddress  out  16  = (Y_BASE + row*8 + r)*256 + col*8 + p
- vram_data  out  9  pixel value
- vram_wren  out  1  vram write strobe

Behaviour:
- Clock port is clock; reset is synchronous, active-high, named rst.
- Reset: state IDLE; busy, done, vram_wren = 0; all address and data outputs = 0; character, row and pixel counters = 0. Reset mid-pass aborts on that edge. No vram_wren after the reset edge. No done pulse.
- RAM timing: the address register changes at edge E0, the RAM samples it at E1, and the controller captures q at E2. Each read therefore costs an address cycle plus a wait cycle.
- States:
  - IDLE: start=1 -> latch colours, idx=0, cram_rdaddress=0, go CADDR. busy=1 from the next cycle.
  - CADDR (1 cycle) -> CWAIT.
  - CWAIT (1 cycle): at exit, capture code=cram_q, font_address={cram_q, 3'd0}, r=0 -> FADDR.
  - FADDR (1 cycle) -> FWAIT.
  - FWAIT (1 cycle): at exit, load shift=font_q, p=0 -> WRITE.
  - WRITE (8 cycles, p=0..7): vram_wren=1; vram_data = shift[7-p] ? fg : bg; vram_wraddress per formula.
  - After p=7:
    - If r<7: r+1, font_address={code, r+1} -> FADDR.
    - Else if idx < COLS*ROWS-1: idx+1, cram_rdaddress=idx+1 -> CADDR.
    - Else -> DONE.
  - DONE (1 cycle): done=1, busy=0 -> IDLE.
- Counters: col = idx mod COLS, row = idx / COLS. Keep col and row as separate counters; col wraps at COLS-1 and increments row.
- Per character: 2 + 8*(2+8) = 82 cycles. Defaults: 512*82 = 41984 busy cycles, 32768 writes.
- vram_wren is 0 in every state except WRITE. vram_wraddress and vram_data are don't-care but held stable when vram_wren=0.
- start while busy or in DONE: ignored, and colour inputs are not resampled. start in the same cycle as rst: reset wins.
- Colours are constant for the whole pass even if the inputs change.
- Address arithmetic is 16-bit unsigned; the parameter limits guarantee no overflow, so no wrap logic is required.

Test Plan:
- Reset/idle: hold rst 3 cycles, no start -> busy=done=vram_wren=0 and all addresses 0 for 100 cycles.
- Single glyph row: cram[0]=0x41, font[0x208]=0x81, fg=0x1FF, bg=0x000, start -> first write 4 cycles after busy rises; vram[0..7] = 1FF, 000 x6, 1FF.
- Addressing: cram[33]=0x02, font[0x10]=0xF0 -> row1 col1 r0 writes addresses 2056..2063 = fg x4, bg x4; last write of the pass goes to address 32767.
- Full-pass timing: start at cycle T -> exactly 32768 vram_wren cycles; busy high for 41984 cycles; done high for exactly one cycle, in the cycle busy falls.
- Ignored start / colour freeze: pulse start and change fg mid-pass -> no restart, write count unchanged, all fg pixels keep the original value.
- Reset mid-operation: assert rst during WRITE of idx=100 -> vram_wren=0 from the next cycle, no done; a new start renders from idx 0 with correct timing.
